// File: rtl/rf_dump_reader_pkg.sv
// Shared types for the register-file dump reader: FSM state encoding,
// the captured beat layout and the checksum fold helper.
package rf_dump_reader_pkg;

  localparam int WD  = 32;
  localparam int SEL = 5;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_READ = 2'd1,
    RD_SEND = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

  // One beat as held between READ capture and the stream handshake.
  typedef struct packed {
    logic [WD-1:0] data1;
    logic [WD-1:0] data0;
    logic          lane1_vld;
    logic          last;
  } beat_t;

  // Checksum contribution of one beat: lane0 always, lane1 only when it
  // holds a real register (single-register tail beats repeat lane0).
  function automatic logic [WD-1:0] beat_fold(input beat_t b);
    logic [WD-1:0] upper;
    if (b.lane1_vld) begin
      upper = b.data1;
    end else begin
      upper = {WD{1'b0}};
    end
    return b.data0 ^ upper;
  endfunction

endpackage

// File: rtl/rf_dump_addr_gen.sv
// Address generator for the dump sweep: holds the current register index
// and the latched last index one bit wider than the address, so a range
// ending at the top register never wraps back to zero.
module rf_dump_addr_gen #(
  parameter int SEL = rf_dump_reader_pkg::SEL
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [SEL-1:0] first_reg,
  input  logic [SEL-1:0] last_reg,
  output logic           range_ok,
  output logic [SEL-1:0] rd_reg_1,
  output logic [SEL-1:0] rd_reg_2,
  output logic           lane1_vld,
  output logic           is_last
);
  import rf_dump_reader_pkg::*;

  localparam logic [SEL:0] ONE   = (SEL+1)'(32'd1);
  localparam logic [SEL:0] TWO   = (SEL+1)'(32'd2);
  localparam logic [SEL:0] THREE = (SEL+1)'(32'd3);

  logic [SEL:0] cur_r;
  logic [SEL:0] last_r;
  logic [SEL:0] rd2_r;
  logic [SEL:0] first_ext;
  logic [SEL:0] last_ext;
  logic [SEL:0] cur_plus2;
  logic [SEL:0] load_rd2;
  logic [SEL:0] step_rd2;

  assign first_ext = {1'b0, first_reg};
  assign last_ext  = {1'b0, last_reg};
  assign range_ok  = (first_ext <= last_ext);
  assign cur_plus2 = cur_r + TWO;

  // Second read port follows cur+1, except on a lone final register where it repeats cur.
  always_comb begin
    load_rd2 = first_ext + ONE;
    step_rd2 = cur_r + THREE;
    if (first_ext == last_ext) begin
      load_rd2 = first_ext;
    end else begin
      load_rd2 = first_ext + ONE;
    end
    if (cur_plus2 == last_r) begin
      step_rd2 = cur_plus2;
    end else begin
      step_rd2 = cur_r + THREE;
    end
  end

  // Range registers: loaded on accepted start, advanced by two per accepted non-final beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_r  <= {(SEL+1){1'b0}};
      last_r <= {(SEL+1){1'b0}};
      rd2_r  <= {(SEL+1){1'b0}};
    end else if (load) begin
      cur_r  <= first_ext;
      last_r <= last_ext;
      rd2_r  <= load_rd2;
    end else if (step) begin
      cur_r  <= cur_plus2;
      last_r <= last_r;
      rd2_r  <= step_rd2;
    end else begin
      cur_r  <= cur_r;
      last_r <= last_r;
      rd2_r  <= rd2_r;
    end
  end

  assign rd_reg_1  = cur_r[SEL-1:0];
  assign rd_reg_2  = rd2_r[SEL-1:0];
  assign lane1_vld = (cur_r != last_r);
  assign is_last   = ((cur_r + ONE) >= last_r);

endmodule

// File: rtl/rf_dump_reader.sv
// Register-file dump reader: sweeps a register range through both read
// ports two registers per beat, streams each beat on valid/ready and
// keeps an XOR checksum of every emitted register word.
module rf_dump_reader #(
  parameter int WD  = rf_dump_reader_pkg::WD,
  parameter int SEL = rf_dump_reader_pkg::SEL,
  parameter logic [WD-1:0] CHK_SEED = {WD{1'b0}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [SEL-1:0]  first_reg_i,
  input  logic [SEL-1:0]  last_reg_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [SEL-1:0]  rd_reg_1_o,
  output logic [SEL-1:0]  rd_reg_2_o,
  input  logic [WD-1:0]   rd_data_1_i,
  input  logic [WD-1:0]   rd_data_2_i,
  output logic            beat_valid_o,
  input  logic            beat_ready_i,
  output logic [2*WD-1:0] beat_data_o,
  output logic            beat_lane1_vld_o,
  output logic            beat_last_o,
  output logic [WD-1:0]   checksum_o
);
  import rf_dump_reader_pkg::*;

  rd_state_e     state_r;
  rd_state_e     state_nxt;
  beat_t         beat_r;
  logic [WD-1:0] checksum_r;
  logic          busy_r;
  logic          done_r;
  logic          valid_r;
  logic          busy_nxt;
  logic          done_nxt;
  logic          valid_nxt;

  logic          accept_start;
  logic          handshake;
  logic          range_ok;
  logic          load;
  logic          step;
  logic          lane1_vld;
  logic          is_last;

  assign accept_start = (state_r == RD_IDLE) && start_i;
  assign handshake    = (state_r == RD_SEND) && beat_ready_i;
  assign load         = accept_start && range_ok;
  assign step         = handshake && !beat_r.last;

  rf_dump_addr_gen #(
    .SEL(SEL)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .first_reg (first_reg_i),
    .last_reg  (last_reg_i),
    .range_ok  (range_ok),
    .rd_reg_1  (rd_reg_1_o),
    .rd_reg_2  (rd_reg_2_o),
    .lane1_vld (lane1_vld),
    .is_last   (is_last)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic; an empty range goes straight to DONE without beats.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      RD_IDLE: begin
        if (start_i) begin
          if (range_ok) begin
            state_nxt = RD_READ;
          end else begin
            state_nxt = RD_DONE;
          end
        end else begin
          state_nxt = RD_IDLE;
        end
      end
      RD_READ: state_nxt = RD_SEND;
      RD_SEND: begin
        if (beat_ready_i) begin
          if (beat_r.last) begin
            state_nxt = RD_DONE;
          end else begin
            state_nxt = RD_READ;
          end
        end else begin
          state_nxt = RD_SEND;
        end
      end
      RD_DONE: state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the status flags come out of flops.
  always_comb begin
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    valid_nxt = 1'b0;
    case (state_nxt)
      RD_IDLE: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
      RD_READ: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
      RD_SEND: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b0;
        valid_nxt = 1'b1;
      end
      RD_DONE: begin
        busy_nxt  = 1'b1;
        done_nxt  = 1'b1;
        valid_nxt = 1'b0;
      end
      default: begin
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Status output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
      valid_r <= valid_nxt;
    end
  end

  // Beat register: captures both read ports and flags at the end of READ, then holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_r <= '{data1: {WD{1'b0}}, data0: {WD{1'b0}}, lane1_vld: 1'b0, last: 1'b0};
    end else if (state_r == RD_READ) begin
      beat_r <= '{data1: rd_data_2_i, data0: rd_data_1_i, lane1_vld: lane1_vld, last: is_last};
    end else begin
      beat_r <= beat_r;
    end
  end

  // Checksum: reseeded on accepted start, folded on each handshake, otherwise held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      checksum_r <= {WD{1'b0}};
    end else if (accept_start) begin
      checksum_r <= CHK_SEED;
    end else if (handshake) begin
      checksum_r <= checksum_r ^ beat_fold(beat_r);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign busy_o           = busy_r;
  assign done_o           = done_r;
  assign beat_valid_o     = valid_r;
  assign beat_data_o      = {beat_r.data1, beat_r.data0};
  assign beat_lane1_vld_o = beat_r.lane1_vld;
  assign beat_last_o      = beat_r.last;
  assign checksum_o       = checksum_r;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader wired to a combinational RegFile model
// preloaded with reg[i] = 0x11*i.
module tb_rf_dump_reader;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [4:0]  first_reg_i;
  logic [4:0]  last_reg_i;
  logic        busy_o;
  logic        done_o;
  logic [4:0]  rd_reg_1_o;
  logic [4:0]  rd_reg_2_o;
  logic [31:0] rd_data_1_i;
  logic [31:0] rd_data_2_i;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [63:0] beat_data_o;
  logic        beat_lane1_vld_o;
  logic        beat_last_o;
  logic [31:0] checksum_o;

  int checks;
  int failures;

  rf_dump_reader dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .first_reg_i      (first_reg_i),
    .last_reg_i       (last_reg_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .rd_reg_1_o       (rd_reg_1_o),
    .rd_reg_2_o       (rd_reg_2_o),
    .rd_data_1_i      (rd_data_1_i),
    .rd_data_2_i      (rd_data_2_i),
    .beat_valid_o     (beat_valid_o),
    .beat_ready_i     (beat_ready_i),
    .beat_data_o      (beat_data_o),
    .beat_lane1_vld_o (beat_lane1_vld_o),
    .beat_last_o      (beat_last_o),
    .checksum_o       (checksum_o)
  );

  // RegFile model, combinational read path
  assign rd_data_1_i = 32'h11 * {27'd0, rd_reg_1_o};
  assign rd_data_2_i = 32'h11 * {27'd0, rd_reg_2_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    start_i = 1'b0;
    first_reg_i = 5'd0;
    last_reg_i = 5'd0;
    beat_ready_i = 1'b1;
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", beat_valid_o, 0);
    check("rst_chk", checksum_o, 0);
    check("rst_addr1", rd_reg_1_o, 0);
    check("rst_addr2", rd_reg_2_o, 0);
    reset = 1'b1;
    step();

    // Sweep 4..7, ready high
    start_i = 1'b1; first_reg_i = 5'd4; last_reg_i = 5'd7;
    step();
    start_i = 1'b0;
    check("t1_read_busy", busy_o, 1);
    check("t1_read_a1", rd_reg_1_o, 4);
    check("t1_read_a2", rd_reg_2_o, 5);
    check("t1_read_valid", beat_valid_o, 0);
    step();
    check("t1_b1_valid", beat_valid_o, 1);
    check("t1_b1_data", beat_data_o, 64'h00000055_00000044);
    check("t1_b1_lane1", beat_lane1_vld_o, 1);
    check("t1_b1_last", beat_last_o, 0);
    step();
    check("t1_read2_valid", beat_valid_o, 0);
    check("t1_read2_a1", rd_reg_1_o, 6);
    check("t1_read2_a2", rd_reg_2_o, 7);
    step();
    check("t1_b2_data", beat_data_o, 64'h00000077_00000066);
    check("t1_b2_last", beat_last_o, 1);
    check("t1_b2_lane1", beat_lane1_vld_o, 1);
    step();
    check("t1_done", done_o, 1);
    check("t1_done_busy", busy_o, 1);
    check("t1_done_valid", beat_valid_o, 0);
    check("t1_chk", checksum_o, 32'h0);
    step();
    check("t1_idle_done", done_o, 0);
    check("t1_idle_busy", busy_o, 0);

    // Sweep 2..4, odd count: tail beat has a single register
    start_i = 1'b1; first_reg_i = 5'd2; last_reg_i = 5'd4;
    step();
    start_i = 1'b0;
    check("t2_read_a2", rd_reg_2_o, 3);
    step();
    check("t2_b1_data", beat_data_o, 64'h00000033_00000022);
    step();
    check("t2_read2_a1", rd_reg_1_o, 4);
    check("t2_read2_a2", rd_reg_2_o, 4);
    step();
    check("t2_b2_data0", beat_data_o[31:0], 32'h44);
    check("t2_b2_lane1", beat_lane1_vld_o, 0);
    check("t2_b2_last", beat_last_o, 1);
    step();
    check("t2_done", done_o, 1);
    check("t2_chk", checksum_o, 32'h55);
    step();

    // Single top register, no address wrap
    start_i = 1'b1; first_reg_i = 5'd31; last_reg_i = 5'd31;
    step();
    start_i = 1'b0;
    check("t3_a1", rd_reg_1_o, 31);
    check("t3_a2", rd_reg_2_o, 31);
    step();
    check("t3_valid", beat_valid_o, 1);
    check("t3_data0", beat_data_o[31:0], 32'h20F);
    check("t3_lane1", beat_lane1_vld_o, 0);
    check("t3_last", beat_last_o, 1);
    step();
    check("t3_done", done_o, 1);
    check("t3_chk", checksum_o, 32'h20F);
    step();

    // Backpressure: ready low for 5 cycles in SEND
    beat_ready_i = 1'b0;
    start_i = 1'b1; first_reg_i = 5'd0; last_reg_i = 5'd1;
    step();
    start_i = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", beat_valid_o, 1);
      check("t4_hold_data", beat_data_o, 64'h00000011_00000000);
      check("t4_hold_a2", rd_reg_2_o, 1);
      check("t4_hold_chk", checksum_o, 32'h0);
      step();
    end
    check("t4_still_valid", beat_valid_o, 1);
    beat_ready_i = 1'b1;
    step();
    check("t4_done", done_o, 1);
    check("t4_valid_drop", beat_valid_o, 0);
    check("t4_chk", checksum_o, 32'h11);
    step();

    // Empty range: first > last
    start_i = 1'b1; first_reg_i = 5'd9; last_reg_i = 5'd3;
    step();
    start_i = 1'b0;
    check("t5_done", done_o, 1);
    check("t5_busy", busy_o, 1);
    check("t5_valid", beat_valid_o, 0);
    check("t5_chk", checksum_o, 32'h0);
    step();
    check("t5_idle_done", done_o, 0);
    check("t5_idle_valid", beat_valid_o, 0);

    // Full sweep with a start pulse while busy, then reset in the 2nd SEND
    start_i = 1'b1; first_reg_i = 5'd0; last_reg_i = 5'd31;
    step();
    first_reg_i = 5'd9; last_reg_i = 5'd3;
    step();
    start_i = 1'b0;
    check("t6_b1_data", beat_data_o, 64'h00000011_00000000);
    step();
    check("t6_read2_a1", rd_reg_1_o, 2);
    check("t6_read2_a2", rd_reg_2_o, 3);
    step();
    check("t6_b2_valid", beat_valid_o, 1);
    check("t6_b2_data", beat_data_o, 64'h00000033_00000022);
    check("t6_b2_last", beat_last_o, 0);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", beat_valid_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_done", done_o, 0);
    check("t6_rst_data", beat_data_o, 64'h0);
    check("t6_rst_a1", rd_reg_1_o, 0);
    check("t6_rst_chk", checksum_o, 32'h0);
    step();
    check("t6_rst_hold_done", done_o, 0);
    reset = 1'b1;
    step();

    // Fresh sweep after reset release
    start_i = 1'b1; first_reg_i = 5'd0; last_reg_i = 5'd1;
    step();
    start_i = 1'b0;
    check("t7_a1", rd_reg_1_o, 0);
    check("t7_a2", rd_reg_2_o, 1);
    step();
    check("t7_data", beat_data_o, 64'h00000011_00000000);
    check("t7_last", beat_last_o, 1);
    step();
    check("t7_done", done_o, 1);
    check("t7_chk", checksum_o, 32'h11);
    step();
    check("t7_idle_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
